core_ctrl_fsm: RTL
==================

// Module: core_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the core datapath. Steps each instruction through fetch,
//  decode, execute, memory and writeback. Takes the decoder's control outputs and drives:
//  - the handshake on the single shared memory port;
//  - the datapath register enables;
//  - next-PC selection.
//  Counts retired instructions. Sits between the decoder and the datapath/memory interface.
// PARAMETERS
//  InstretWidth  64  width of retired-instruction counter
// PORTS
//  clk_i           in   1    clock; single clock domain
//  rst_i           in   1    reset, synchronous, active-high
//  mem_valid_o     out  1    memory request valid
//  mem_ready_i     in   1    memory accepts request this cycle
//  mem_we_o        out  1    request is a store
//  mem_is_fetch_o  out  1    request is an instruction fetch; selects PC as address
//  mem_rvalid_i    in   1    read response valid (fetch or load)
//  ir_we_o         out  1    latch fetched instruction into IR
//  mdr_we_o        out  1    latch load data into MDR
//  alu_we_o        out  1    latch ALU result register
//  rf_we_o         out  1    register-file write enable
//  pc_we_o         out  1    PC update enable
//  pc_sel_o        out  2    next-PC source (pc_sel_e)
//  reg_wb_i        in   1    decoder: instruction writes rd
//  mem_read_i      in   1    decoder: load
//  mem_write_i     in   1    decoder: store
//  branch_i        in   1    decoder: conditional branch
//  jump_i          in   2    decoder: None/Jal/Jalr
//  branch_taken_i  in   1    datapath branch comparison result; valid in EXECUTE and WB
//  retire_o        out  1    one-cycle pulse per retired instruction
//  instret_o       out  InstretWidth  retired-instruction count
// BEHAVIOUR
//  Reset state and outputs
//  - On rst_i: state <= FETCH; instret_o <= 0.
//  - All strobes are 0 during the reset cycle.
//  - rst_i mid-instruction aborts it: no retire, no PC/RF write.
//  - The memory side is reset by the same rst_i, so no stale response survives.
//  FETCH
//  - Drives mem_valid_o=1 and mem_is_fetch_o=1.
//  - If mem_ready_i: go to FETCH_WAIT. Otherwise hold, with request attributes stable.
//  FETCH_WAIT
//  - When mem_rvalid_i: ir_we_o=1 (same cycle) and go to DECODE. Otherwise hold.
//  DECODE
//  - One cycle. Decoder outputs are valid from IR. Go to EXECUTE.
//  EXECUTE
//  - alu_we_o=1.
//  - If mem_read_i|mem_write_i: go to MEM. Otherwise go to WB.
//  MEM
//  - Drives mem_valid_o=1, mem_we_o=mem_write_i, mem_is_fetch_o=0.
//  - On mem_ready_i: a store goes to WB; a load goes to MEM_WAIT.
//  MEM_WAIT
//  - When mem_rvalid_i: mdr_we_o=1 and go to WB.
//  WB
//  - rf_we_o=reg_wb_i; pc_we_o=1; retire_o=1; instret++; go to FETCH.
//  - pc_sel_o priority:
//    - jump_i==Jalr -> PcAlu;
//    - jump_i==Jal, or branch_i&branch_taken_i -> PcTarget (pc+imm);
//    - otherwise PcPlus4.
//  - pc_sel_o = PcPlus4 outside WB.
//  Memory protocol
//  - Only one outstanding request.
//  - The response arrives at the earliest the cycle after acceptance.
//  - Stores produce no response.
//  - mem_rvalid_i outside FETCH_WAIT/MEM_WAIT is ignored and is an assertion failure.
//  Latency with zero-wait memory (ready same cycle, rvalid next cycle)
//  - ALU/branch/jump/lui/auipc: 5 cycles. Store: 6 cycles. Load: 7 cycles.
//  Other rules
//  - Unsupported opcodes decode to all-zero controls: they execute as a NOP and still retire.
//  - instret_o wraps from 2^InstretWidth-1 to 0.
//  - mem_valid_o, mem_we_o and mem_is_fetch_o depend on state only.
//  - ir_we_o and mdr_we_o are qualified by mem_rvalid_i.
// STRUCTURE
//  - core_pkg gains:
//    - ctrl_state_e {Fetch, FetchWait, Decode, Execute, Mem, MemWait, Wb};
//    - pc_sel_e {PcPlus4, PcTarget, PcAlu}.
//  - Existing jump enum (None/Jal/Jalr) is reused from core_pkg.
//  - One sub-module, instret_counter: enable/wrap counter of width InstretWidth.
//  - The FSM stays inline.
// TESTING
//  1. ADD, zero-wait memory -> states F,FW,D,E,WB; retire_o in cycle 5; rf_we_o=1;
//     pc_sel_o=PcPlus4; instret_o=1.
//  2. LW with mem_ready_i low for 3 cycles in MEM -> mem_valid_o held 4 cycles;
//     mdr_we_o on rvalid; retire 10 cycles after fetch start.
//  3. SW -> mem_we_o=1 in MEM; no MEM_WAIT; rf_we_o=0 in WB; retire in cycle 6.
//  4. BEQ taken/not-taken -> PcTarget or PcPlus4 in WB; JAL -> PcTarget; JALR -> PcAlu;
//     rf_we_o=1 for both jumps.
//  5. rst_i asserted in MEM_WAIT -> next cycle FETCH; instret_o=0; no retire/pc_we;
//     fetch restarts.
//  6. Preload counter to 2^64-1, retire one instruction -> instret_o=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: jump kind, control-sequencer states and next-PC source.
package core_pkg;

    typedef enum logic [1:0] {
        JumpNone = 2'd0,
        JumpJal  = 2'd1,
        JumpJalr = 2'd2
    } jump_e;

    typedef enum logic [2:0] {
        Fetch,
        FetchWait,
        Decode,
        Execute,
        Mem,
        MemWait,
        Wb
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PcPlus4  = 2'd0,
        PcTarget = 2'd1,
        PcAlu    = 2'd2
    } pc_sel_e;

    localparam int unsigned InstretWidthDefault = 64;

    // Jalr outranks everything; Jal and a taken branch share the pc+imm adder.
    function automatic pc_sel_e next_pc_sel(logic [1:0] jump, logic branch, logic taken);
        if (jump == JumpJalr)                    return PcAlu;
        else if (jump == JumpJal || (branch && taken)) return PcTarget;
        else                                     return PcPlus4;
    endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter; wraps naturally at 2^Width.
module instret_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    // Count one per enabled cycle; overflow wraps to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i)     count_q <= '0;
        else if (en_i) count_q <= count_q + Width'(1);
    end

    assign count_o = count_q;

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/mem/writeback over one
// shared memory port, with datapath enables, next-PC select and retire count.
module core_ctrl_fsm
    import core_pkg::*;
#(
    parameter int unsigned InstretWidth = InstretWidthDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic                    mem_we_o,
    output logic                    mem_is_fetch_o,
    input  logic                    mem_rvalid_i,
    output logic                    ir_we_o,
    output logic                    mdr_we_o,
    output logic                    alu_we_o,
    output logic                    rf_we_o,
    output logic                    pc_we_o,
    output logic [1:0]              pc_sel_o,
    input  logic                    reg_wb_i,
    input  logic                    mem_read_i,
    input  logic                    mem_write_i,
    input  logic                    branch_i,
    input  logic [1:0]              jump_i,
    input  logic                    branch_taken_i,
    output logic                    retire_o,
    output logic [InstretWidth-1:0] instret_o
);

    ctrl_state_e state_q, state_d;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= Fetch;
        else       state_q <= state_d;
    end

    // Next state and strobes. Request attributes come from state only;
    // IR/MDR latches are qualified by the read response.
    always_comb begin
        state_d        = state_q;
        mem_valid_o    = 1'b0;
        mem_we_o       = 1'b0;
        mem_is_fetch_o = 1'b0;
        ir_we_o        = 1'b0;
        mdr_we_o       = 1'b0;
        alu_we_o       = 1'b0;
        rf_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = PcPlus4;
        retire_o       = 1'b0;
        unique case (state_q)
            Fetch: begin
                mem_valid_o    = 1'b1;
                mem_is_fetch_o = 1'b1;
                if (mem_ready_i) state_d = FetchWait;
            end
            FetchWait: begin
                if (mem_rvalid_i) begin
                    ir_we_o = 1'b1;
                    state_d = Decode;
                end
            end
            Decode: state_d = Execute;
            Execute: begin
                alu_we_o = 1'b1;
                state_d  = (mem_read_i || mem_write_i) ? Mem : Wb;
            end
            Mem: begin
                mem_valid_o = 1'b1;
                mem_we_o    = mem_write_i;
                if (mem_ready_i) state_d = mem_write_i ? Wb : MemWait;
            end
            MemWait: begin
                if (mem_rvalid_i) begin
                    mdr_we_o = 1'b1;
                    state_d  = Wb;
                end
            end
            Wb: begin
                rf_we_o  = reg_wb_i;
                pc_we_o  = 1'b1;
                retire_o = 1'b1;
                pc_sel_o = next_pc_sel(jump_i, branch_i, branch_taken_i);
                state_d  = Fetch;
            end
            default: state_d = Fetch;
        endcase
        // Nothing may commit or request during the reset cycle.
        if (rst_i) begin
            mem_valid_o    = 1'b0;
            mem_we_o       = 1'b0;
            mem_is_fetch_o = 1'b0;
            ir_we_o        = 1'b0;
            mdr_we_o       = 1'b0;
            alu_we_o       = 1'b0;
            rf_we_o        = 1'b0;
            pc_we_o        = 1'b0;
            pc_sel_o       = PcPlus4;
            retire_o       = 1'b0;
        end
    end

    instret_counter #(.Width(InstretWidth)) u_instret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (retire_o),
        .count_o (instret_o)
    );

    // A read response is only legal while a read is outstanding.
    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> (state_q == FetchWait || state_q == MemWait));

endmodule
